// File: rtl/quire_arb_pkg.sv
// quire_arb_pkg: shared types and defaults for the quire window arbiter.
//   arb_state_e : arbiter FSM states (IDLE waits for a sow, OWN streams one window)
//   id_w()      : width of a requester id
//   DEF_DATA_W  : product beat width {fraction, scale, sign, zero, NaR}
//   DEF_RES_W   : quire result width {data, NaR, sign, zero}
package quire_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   // Posit format feeding the quire.
   localparam int POSIT_N  = 16;
   localparam int POSIT_ES = 1;

   // Product fraction kept by the multiplier and the signed product scale range.
   localparam int PROD_FRAC_W  = 2 * (POSIT_N - POSIT_ES - 4);
   localparam int PROD_SCALE_W = $clog2(POSIT_N) + POSIT_ES + 2;
   localparam int DEF_DATA_W   = PROD_FRAC_W + PROD_SCALE_W + 3;

   // Rounded quire read-out plus its three flag bits.
   localparam int QUIRE_OUT_W = 4 * POSIT_N - 3;
   localparam int DEF_RES_W   = QUIRE_OUT_W + 3;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/quire_tag_fifo.sv
// quire_tag_fifo: small synchronous FIFO holding the requester id of every
// beat sent to the quire, so results can be tagged in order.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push_i, push_data_i : write strobe and id (ignored while full)
//   pop_i               : read strobe (ignored while empty)
//   head_o              : fall-through head, 0 while empty
//   full_o, empty_o     : occupancy flags
module quire_tag_fifo
   import quire_arb_pkg::*;
#(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter: grants whole sow..eow windows from NUM_REQ product
// streams to one quire, round-robin, and tags each quire result with the id
// of the requester whose window produced it.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_rts_i/req_rtr_o             : per-requester beat handshake
//   req_sow_i/req_eow_i/req_data_i  : per-requester framing and payload
//   q_rts_o/q_rtr_i, q_sow_o/q_eow_o/q_data_o : beat stream to the quire
//   q_res_rts_i/q_res_rtr_o/q_res_data_i      : results from the quire
//   out_rts_o/out_rtr_i/out_data_o/out_id_o   : tagged results downstream
//   err_o                           : sticky protocol error
// Build option QUIRE_ARB_PROTO_CHECK_EN: discard and flag non-sow beats in
// IDLE and mid-window sow beats; otherwise those are held / forwarded.
module quire_window_arbiter
   import quire_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int RES_W     = DEF_RES_W,
   parameter int TAG_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_rts_i,
   output logic [NUM_REQ-1:0]        req_rtr_o,
   input  logic [NUM_REQ-1:0]        req_sow_i,
   input  logic [NUM_REQ-1:0]        req_eow_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic                      q_rts_o,
   output logic                      q_sow_o,
   output logic                      q_eow_o,
   output logic [DATA_W-1:0]         q_data_o,
   input  logic                      q_rtr_i,
   input  logic                      q_res_rts_i,
   input  logic [RES_W-1:0]          q_res_data_i,
   output logic                      q_res_rtr_o,
   output logic                      out_rts_o,
   output logic [RES_W-1:0]          out_data_o,
   output logic [id_w(NUM_REQ)-1:0]  out_id_o,
   input  logic                      out_rtr_i,
   output logic                      err_o
);

   localparam int ID_W = id_w(NUM_REQ);

   arb_state_e        state_q;
   logic [ID_W-1:0]   owner_q, rr_ptr_q;
   logic              err_q;
`ifdef QUIRE_ARB_PROTO_CHECK_EN
   logic              first_q;
`endif

   logic [DATA_W-1:0] req_data_arr [NUM_REQ];
   logic [NUM_REQ-1:0] sow_req;
   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic              in_own, own_rts, own_eow, mid_sow_drop;
   logic              xfer, err_set;
   logic              tag_full, tag_empty, tag_pop;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
   end

   assign sow_req = req_rts_i & req_sow_i;
   assign in_own  = (state_q == OWN);
   assign own_rts = req_rts_i[owner_q];
   assign own_eow = req_eow_i[owner_q];

   // First sow requester at or after rr_ptr: scanning downwards lets the
   // closest candidate overwrite farther ones.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = rr_ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (sow_req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
`ifdef QUIRE_ARB_PROTO_CHECK_EN
      mid_sow_drop = in_own & own_rts & req_sow_i[owner_q] & ~first_q;
`else
      mid_sow_drop = 1'b0;
`endif
      q_rts_o   = in_own & own_rts & ~tag_full & ~mid_sow_drop;
      q_sow_o   = in_own & req_sow_i[owner_q];
      q_eow_o   = in_own & own_eow;
      q_data_o  = in_own ? req_data_arr[owner_q] : '0;
      req_rtr_o = '0;
      if (in_own) begin
         // A dropped beat is always accepted so the window keeps moving.
         req_rtr_o[owner_q] = mid_sow_drop | (q_rtr_i & ~tag_full);
      end
`ifdef QUIRE_ARB_PROTO_CHECK_EN
      else begin
         req_rtr_o = req_rts_i & ~req_sow_i;
      end
`endif
      xfer    = q_rts_o & q_rtr_i;
      err_set = q_res_rts_i & tag_empty;
`ifdef QUIRE_ARB_PROTO_CHECK_EN
      err_set = err_set | mid_sow_drop | (~in_own & |(req_rts_i & ~req_sow_i));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
`ifdef QUIRE_ARB_PROTO_CHECK_EN
         first_q  <= 1'b0;
`endif
      end else begin
         if (err_set) err_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  owner_q <= grant_id;
                  state_q <= OWN;
`ifdef QUIRE_ARB_PROTO_CHECK_EN
                  first_q <= 1'b1;
`endif
               end
            end
            OWN: begin
               if (xfer) begin
`ifdef QUIRE_ARB_PROTO_CHECK_EN
                  first_q <= 1'b0;
`endif
                  if (own_eow) begin
                     state_q  <= IDLE;
                     rr_ptr_q <= (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_rts_o   = q_res_rts_i & ~tag_empty;
   assign q_res_rtr_o = out_rtr_i & ~tag_empty;
   assign out_data_o  = q_res_data_i;
   assign tag_pop     = out_rts_o & out_rtr_i;
   assign err_o       = err_q;

   quire_tag_fifo #(
      .W     (ID_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (xfer),
      .push_data_i (owner_q),
      .pop_i       (tag_pop),
      .head_o      (out_id_o),
      .full_o      (tag_full),
      .empty_o     (tag_empty)
   );

endmodule

// File: tb/tb_quire_window_arbiter.sv
module tb_quire_window_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 32;
   localparam int RW    = 64;
   localparam int DEPTH = 4;
`ifdef QUIRE_ARB_PROTO_CHECK_EN
   localparam bit PROTO = 1'b1;
`else
   localparam bit PROTO = 1'b0;
`endif

   logic             clk, rst_n;
   logic [NR-1:0]    req_rts_i, req_rtr_o, req_sow_i, req_eow_i;
   logic [NR*DW-1:0] req_data_i;
   logic             q_rts_o, q_sow_o, q_eow_o, q_rtr_i;
   logic [DW-1:0]    q_data_o;
   logic             q_res_rts_i, q_res_rtr_o;
   logic [RW-1:0]    q_res_data_i, out_data_o;
   logic             out_rts_o, out_rtr_i, err_o;
   logic [1:0]       out_id_o;

   quire_window_arbiter #(
      .NUM_REQ(NR), .DATA_W(DW), .RES_W(RW), .TAG_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_rts_i(req_rts_i), .req_rtr_o(req_rtr_o), .req_sow_i(req_sow_i),
      .req_eow_i(req_eow_i), .req_data_i(req_data_i),
      .q_rts_o(q_rts_o), .q_sow_o(q_sow_o), .q_eow_o(q_eow_o), .q_data_o(q_data_o),
      .q_rtr_i(q_rtr_i), .q_res_rts_i(q_res_rts_i), .q_res_data_i(q_res_data_i),
      .q_res_rtr_o(q_res_rtr_o), .out_rts_o(out_rts_o), .out_data_o(out_data_o),
      .out_id_o(out_id_o), .out_rtr_i(out_rtr_i), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          sow;
      logic          eow;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct packed {
      logic [NR-1:0] rts, sow, eow;
      logic          q_rtr, res_rts, out_rtr;
      logic          e_qrts;
      logic [NR-1:0] e_rtr;
      logic          e_sow, e_eow, e_out;
      logic [1:0]    e_id;
   } vec_t;

   int    n_vec = 0, n_mis = 0, cyc = 0, seq = 0;
   int    p_rts = 100, p_qrtr = 100, p_res = 100, p_out = 100;
   beat_t rq[NR][$];
   // Reference: owner of the window in flight (-1 between windows), next
   // round-robin start, ids in the quire awaiting results, sticky error.
   int    m_owner = -1, m_ptr = 0;
   int    tagq[$];
   bit    m_err = 1'b0;
   // Observed DUT activity for the directed checks.
   int    win_log[$], xfer_cyc[$];
   int    n_dut_xfer = 0, n_dut_res = 0;

   function automatic bit pct(input int p);
      return ($urandom_range(99) < p);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic add_window(input int r, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.sow  = (k == 0);
         b.eow  = (k == len - 1);
         b.data = (32'(r) << 24) | 32'(seq & 24'hFFFFFF);
         seq++;
         rq[r].push_back(b);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_q_rts"}, q_rts_o, 0);
      chk({tag, "_req_rtr"}, req_rtr_o, 0);
      chk({tag, "_q_sow"}, q_sow_o, 0);
      chk({tag, "_q_eow"}, q_eow_o, 0);
      chk({tag, "_q_data"}, q_data_o, 0);
      chk({tag, "_q_res_rtr"}, q_res_rtr_o, 0);
      chk({tag, "_out_rts"}, out_rts_o, 0);
      chk({tag, "_out_data"}, out_data_o, 0);
      chk({tag, "_out_id"}, out_id_o, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   task automatic do_reset(input string tag);
      req_rts_i = '0; req_sow_i = '0; req_eow_i = '0; req_data_i = '0;
      q_rtr_i = 1'b0; q_res_rts_i = 1'b0; q_res_data_i = '0; out_rtr_i = 1'b0;
      rst_n = 1'b0;
      #2;
      check_idle_outputs(tag);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_owner = -1; m_ptr = 0; m_err = 1'b0;
      tagq.delete();
      for (int i = 0; i < NR; i++) rq[i].delete();
      win_log.delete(); xfer_cyc.delete();
      n_dut_xfer = 0; n_dut_res = 0;
   endtask

   // One clock of randomized driving, checked against the reference rules.
   task automatic step();
      logic [NR-1:0] e_rtr;
      logic          e_qrts, e_out, full, empty, pop, push;
      int            o, pick, idx, w;
      beat_t         b;
      for (int i = 0; i < NR; i++) begin
         if (rq[i].size() > 0) begin
            b = rq[i][0];
            req_rts_i[i] = pct(p_rts);
            req_sow_i[i] = b.sow;
            req_eow_i[i] = b.eow;
            req_data_i[i*DW +: DW] = b.data;
         end else begin
            req_rts_i[i] = 1'b0;
            req_sow_i[i] = 1'b0;
            req_eow_i[i] = 1'b0;
            req_data_i[i*DW +: DW] = $urandom;
         end
      end
      q_rtr_i      = pct(p_qrtr);
      out_rtr_i    = pct(p_out);
      q_res_rts_i  = (tagq.size() > 0) && pct(p_res);
      q_res_data_i = {$urandom, $urandom};
      @(negedge clk);
      full  = (tagq.size() >= DEPTH);
      empty = (tagq.size() == 0);
      o = m_owner;
      e_rtr = '0;
      e_qrts = 1'b0;
      if (o >= 0) begin
         e_qrts   = req_rts_i[o] && !full;
         e_rtr[o] = q_rtr_i && !full;
      end
`ifdef QUIRE_ARB_PROTO_CHECK_EN
      if (o < 0) e_rtr = req_rts_i & ~req_sow_i;
`endif
      e_out = q_res_rts_i && !empty;
      chk("q_rts", q_rts_o, e_qrts);
      chk("req_rtr", req_rtr_o, e_rtr);
      if (e_qrts) begin
         chk("q_data", q_data_o, req_data_i[o*DW +: DW]);
         chk("q_sow", q_sow_o, req_sow_i[o]);
         chk("q_eow", q_eow_o, req_eow_i[o]);
      end
      chk("out_rts", out_rts_o, e_out);
      chk("q_res_rtr", q_res_rtr_o, out_rtr_i && !empty);
      if (e_out) begin
         chk("out_id", out_id_o, tagq[0]);
         chk("out_data", out_data_o, q_res_data_i);
      end
      chk("err", err_o, m_err);
      // Log what the DUT actually did.
      if (q_rts_o && q_rtr_i) begin
         w = -1;
         for (int i = 0; i < NR; i++) if (req_rtr_o[i]) w = i;
         n_dut_xfer++;
         xfer_cyc.push_back(cyc);
         if (q_sow_o) win_log.push_back(w);
         $display("cyc %0d beat   req=%0d data=%h sow=%b eow=%b", cyc, w, q_data_o, q_sow_o, q_eow_o);
      end
      if (out_rts_o && out_rtr_i) begin
         n_dut_res++;
         $display("cyc %0d result id=%0d data=%h", cyc, out_id_o, out_data_o);
      end
      // Advance the reference.
      pop  = e_out && out_rtr_i;
      push = e_qrts && q_rtr_i;
      if (q_res_rts_i && empty) m_err = 1'b1;
      if (pop) void'(tagq.pop_front());
      if (o < 0) begin
         pick = -1;
         for (int k = NR - 1; k >= 0; k--) begin
            idx = (m_ptr + k) % NR;
            if (req_rts_i[idx] && req_sow_i[idx]) pick = idx;
         end
`ifdef QUIRE_ARB_PROTO_CHECK_EN
         for (int i = 0; i < NR; i++) begin
            if (req_rts_i[i] && !req_sow_i[i]) begin
               void'(rq[i].pop_front());
               m_err = 1'b1;
            end
         end
`endif
         m_owner = pick;
      end else if (push) begin
         b = rq[o].pop_front();
         tagq.push_back(o);
         if (b.eow) begin
            m_owner = -1;
            m_ptr = (o + 1) % NR;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   vec_t tbl[9];
   vec_t v;
   int   tmp;

   initial begin
      // Single 3-beat window from requester 2, then its three results.
      tbl[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[2] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[3] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd0};
      tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2};
      tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2};
      tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2};
      tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2};
      tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};

      do_reset("rst");
      for (int k = 0; k < 9; k++) begin
         v = tbl[k];
         req_rts_i = v.rts; req_sow_i = v.sow; req_eow_i = v.eow;
         for (int i = 0; i < NR; i++)
            req_data_i[i*DW +: DW] = (i == 2) ? 32'(32'hA0 + k) : $urandom;
         q_rtr_i = v.q_rtr; q_res_rts_i = v.res_rts; out_rtr_i = v.out_rtr;
         q_res_data_i = {32'hC0DE0000, 32'(k)};
         @(negedge clk);
         chk("tbl_q_rts", q_rts_o, v.e_qrts);
         chk("tbl_req_rtr", req_rtr_o, v.e_rtr);
         if (v.e_qrts) begin
            chk("tbl_q_data", q_data_o, 32'(32'hA0 + k));
            chk("tbl_q_sow", q_sow_o, v.e_sow);
            chk("tbl_q_eow", q_eow_o, v.e_eow);
         end
         chk("tbl_out_rts", out_rts_o, v.e_out);
         if (v.e_out) begin
            chk("tbl_out_id", out_id_o, v.e_id);
            chk("tbl_out_data", out_data_o, {32'hC0DE0000, 32'(k)});
         end
         chk("tbl_err", err_o, 0);
         $display("row %0d q_rts=%b rtr=%b out_rts=%b id=%0d", k, q_rts_o, req_rtr_o, out_rts_o, out_id_o);
         @(posedge clk);
         #1;
      end

      // Round robin: all four hold a window, requester 0 has a second one.
      do_reset("rr");
      for (int i = 0; i < NR; i++) add_window(i, 2);
      add_window(0, 2);
      p_rts = 100; p_qrtr = 100; p_res = 100; p_out = 100;
      for (int k = 0; k < 20; k++) step();
      chk("rr_windows", win_log.size(), 5);
      if (win_log.size() == 5) begin
         chk("rr_order0", win_log[0], 0);
         chk("rr_order1", win_log[1], 1);
         chk("rr_order2", win_log[2], 2);
         chk("rr_order3", win_log[3], 3);
         chk("rr_order4", win_log[4], 0);
      end

      // Back-to-back single-beat windows: one every second cycle.
      do_reset("sb");
      for (int k = 0; k < 4; k++) add_window(1, 1);
      for (int k = 0; k < 12; k++) step();
      chk("sb_count", xfer_cyc.size(), 4);
      for (int k = 1; k < xfer_cyc.size(); k++)
         chk("sb_spacing", xfer_cyc[k] - xfer_cyc[k-1], 2);

      // Tag FIFO full: downstream stalled, only DEPTH beats may go.
      do_reset("full");
      add_window(1, 6);
      p_out = 0;
      for (int k = 0; k < 10; k++) step();
      chk("full_beats", n_dut_xfer, DEPTH);
      p_out = 100;
      for (int k = 0; k < 20; k++) step();
      chk("full_total_beats", n_dut_xfer, 6);
      chk("full_total_results", n_dut_res, 6);

      // Result with no tag outstanding.
      do_reset("empty");
      q_res_rts_i = 1'b1; out_rtr_i = 1'b1; q_res_data_i = 64'h1234;
      @(negedge clk);
      chk("empty_out_rts", out_rts_o, 0);
      chk("empty_q_res_rtr", q_res_rtr_o, 0);
      @(posedge clk);
      #1;
      q_res_rts_i = 1'b0;
      @(negedge clk);
      chk("empty_err", err_o, 1);
      $display("empty-tag result err=%b", err_o);
      @(posedge clk);
      #1;

      // Non-sow beat while idle.
      do_reset("proto");
      req_rts_i = 4'b0001; req_sow_i = '0; req_data_i = '1;
      @(negedge clk);
      chk("proto_rtr", req_rtr_o, {3'b000, PROTO});
      chk("proto_q_rts", q_rts_o, 0);
      @(posedge clk);
      #1;
      req_rts_i = '0;
      @(negedge clk);
      chk("proto_err", err_o, PROTO);
      $display("non-sow idle beat rtr-err=%b", err_o);
      @(posedge clk);
      #1;

      // Reset in the middle of a 4-beat window.
      do_reset("mw_pre");
      add_window(3, 4);
      for (int k = 0; k < 20 && n_dut_xfer < 1; k++) step();
      chk("mw_beats_before_reset", n_dut_xfer, 1);
      do_reset("mw");
      add_window(2, 1);
      add_window(0, 1);
      for (int k = 0; k < 6; k++) step();
      tmp = (win_log.size() > 0) ? win_log[0] : -1;
      chk("mw_first_grant", tmp, 0);

      // Randomized traffic.
      do_reset("rnd");
      for (int c = 0; c < 800; c++) begin
         if (c % 100 == 0) begin
            p_rts  = $urandom_range(30, 100);
            p_qrtr = $urandom_range(20, 100);
            p_res  = $urandom_range(20, 100);
            p_out  = $urandom_range(0, 100);
         end
         for (int i = 0; i < NR; i++)
            if (rq[i].size() == 0 && pct(30)) add_window(i, $urandom_range(1, 4));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
